// File: rtl/bus_xfer_splitter.sv
// Splits one 1/2/4-byte transfer at any alignment into 68000 16-bit bus cycles,
// drives the bus-cycle FSM controls and assembles a single right-aligned response.
module bus_xfer_splitter #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_write,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_cyc_activate,
    output logic                  o_cyc_must_continue,
    output logic [ADDR_WIDTH-1:0] o_cyc_addr,
    output logic                  o_cyc_uds,
    output logic                  o_cyc_lds,
    output logic                  o_cyc_write,
    output logic [15:0]           o_cyc_wdata,
    input  logic                  i_cyc_done,
    input  logic [15:0]           i_cyc_rdata,
    input  logic                  i_cyc_berr,
    output logic                  o_resp_valid,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic                  r_word, w_word;
    logic                  r_uds, w_uds;
    logic                  r_lds, w_lds;
    logic                  r_write, w_write;
    logic [15:0]           r_wdata, w_wdata;
    logic [1:0]            r_rem, w_rem;
    logic [31:0]           r_sr, w_sr;
    logic [31:0]           r_acc, w_acc;
    logic [31:0]           r_resp_rdata, w_resp_rdata;
    logic                  r_resp_err, w_resp_err;

    logic                  w_accept;
    logic [2:0]            w_bytes;
    logic                  w_first_word;
    logic [2:0]            w_first_rem;
    logic [31:0]           w_load_sr;
    logic [ADDR_WIDTH-1:0] w_step_addr;
    logic                  w_step_word;
    logic [1:0]            w_step_rem;
    logic [31:0]           w_step_sr;
    logic [7:0]            w_lane;
    logic [31:0]           w_acc_upd;

    // Byte cycles replicate the byte on both lanes; the strobe picks the live one.
    function automatic logic [15:0] lane_data(input logic [31:0] sr, input logic word);
        return word ? sr[31:16] : {sr[31:24], sr[31:24]};
    endfunction

    assign w_accept = i_req_valid && (r_state == S_IDLE);

    always_comb begin
        w_bytes   = 3'd0;
        w_load_sr = 32'h0;
        unique case (i_req_size)
            2'b00: begin
                w_bytes   = 3'd1;
                w_load_sr = {i_req_wdata[7:0], 24'h0};
            end
            2'b01: begin
                w_bytes   = 3'd2;
                w_load_sr = {i_req_wdata[15:0], 16'h0};
            end
            2'b10: begin
                w_bytes   = 3'd4;
                w_load_sr = i_req_wdata;
            end
            default: begin
                w_bytes   = 3'd0;
                w_load_sr = 32'h0;
            end
        endcase
    end

    assign w_first_word = (i_req_size != 2'b00) && !i_req_addr[0];
    assign w_first_rem  = w_bytes - (w_first_word ? 3'd2 : 3'd1);

    // Next cycle: word only when aligned and at least two bytes remain.
    assign w_step_addr = r_addr + (r_word ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
    assign w_step_word = !w_step_addr[0] && r_rem[1];
    assign w_step_rem  = r_rem - (w_step_word ? 2'd2 : 2'd1);
    assign w_step_sr   = r_word ? {r_sr[15:0], 16'h0} : {r_sr[23:0], 8'h0};

    assign w_lane    = r_addr[0] ? i_cyc_rdata[7:0] : i_cyc_rdata[15:8];
    assign w_acc_upd = r_word ? {r_acc[15:0], i_cyc_rdata} : {r_acc[23:0], w_lane};

    always_comb begin
        w_state      = r_state;
        w_addr       = r_addr;
        w_word       = r_word;
        w_uds        = r_uds;
        w_lds        = r_lds;
        w_write      = r_write;
        w_wdata      = r_wdata;
        w_rem        = r_rem;
        w_sr         = r_sr;
        w_acc        = r_acc;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = r_resp_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_req_size == 2'b11) begin
                        w_state      = S_RESP;
                        w_resp_err   = 1'b1;
                        w_resp_rdata = 32'h0;
                    end else begin
                        w_state = S_ISSUE;
                        w_addr  = i_req_addr;
                        w_word  = w_first_word;
                        w_uds   = w_first_word || !i_req_addr[0];
                        w_lds   = w_first_word || i_req_addr[0];
                        w_write = i_req_write;
                        w_sr    = w_load_sr;
                        w_wdata = lane_data(w_load_sr, w_first_word);
                        w_rem   = w_first_rem[1:0];
                        w_acc   = 32'h0;
                    end
                end
            end
            S_ISSUE: begin
                w_state = S_BUSY;
            end
            S_BUSY: begin
                if (i_cyc_done) begin
                    if (i_cyc_berr || (r_rem == 2'd0)) begin
                        w_state      = S_RESP;
                        w_resp_err   = i_cyc_berr;
                        w_resp_rdata = (i_cyc_berr || r_write) ? 32'h0 : w_acc_upd;
                        w_acc        = w_acc_upd;
                        w_addr       = '0;
                        w_word       = 1'b0;
                        w_uds        = 1'b0;
                        w_lds        = 1'b0;
                        w_write      = 1'b0;
                        w_wdata      = 16'h0;
                        w_rem        = 2'd0;
                    end else begin
                        w_addr  = w_step_addr;
                        w_word  = w_step_word;
                        w_uds   = w_step_word || !w_step_addr[0];
                        w_lds   = w_step_word || w_step_addr[0];
                        w_sr    = w_step_sr;
                        w_wdata = lane_data(w_step_sr, w_step_word);
                        w_rem   = w_step_rem;
                        w_acc   = w_acc_upd;
                    end
                end
            end
            S_RESP: begin
                w_state      = S_IDLE;
                w_resp_err   = 1'b0;
                w_resp_rdata = 32'h0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_word       <= 1'b0;
            r_uds        <= 1'b0;
            r_lds        <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= 16'h0;
            r_rem        <= 2'd0;
            r_sr         <= 32'h0;
            r_acc        <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_addr       <= w_addr;
            r_word       <= w_word;
            r_uds        <= w_uds;
            r_lds        <= w_lds;
            r_write      <= w_write;
            r_wdata      <= w_wdata;
            r_rem        <= w_rem;
            r_sr         <= w_sr;
            r_acc        <= w_acc;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
        end
    end

    // A bus error cancels continuation in the same cycle the FSM samples it.
    assign o_cyc_must_continue = (r_rem != 2'd0) && !i_cyc_berr;

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_cyc_activate = (r_state == S_ISSUE);
    assign o_resp_valid   = (r_state == S_RESP);
    assign o_cyc_addr     = r_addr;
    assign o_cyc_uds      = r_uds;
    assign o_cyc_lds      = r_lds;
    assign o_cyc_write    = r_write;
    assign o_cyc_wdata    = r_wdata;
    assign o_resp_rdata   = r_resp_rdata;
    assign o_resp_err     = r_resp_err;

endmodule

// File: tb/tb_bus_xfer_splitter.sv
// Scoreboard bench for bus_xfer_splitter with a simple bus-cycle FSM responder.
module tb_bus_xfer_splitter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr;
    logic [1:0]    i_req_size;
    logic          i_req_write;
    logic [31:0]   i_req_wdata;
    logic          o_cyc_activate;
    logic          o_cyc_must_continue;
    logic [AW-1:0] o_cyc_addr;
    logic          o_cyc_uds;
    logic          o_cyc_lds;
    logic          o_cyc_write;
    logic [15:0]   o_cyc_wdata;
    logic          i_cyc_done;
    logic [15:0]   i_cyc_rdata;
    logic          i_cyc_berr;
    logic          o_resp_valid;
    logic [31:0]   o_resp_rdata;
    logic          o_resp_err;

    bus_xfer_splitter #(.ADDR_WIDTH(AW)) dut (
        .i_clk               (clk),
        .i_reset             (i_reset),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_addr          (i_req_addr),
        .i_req_size          (i_req_size),
        .i_req_write         (i_req_write),
        .i_req_wdata         (i_req_wdata),
        .o_cyc_activate      (o_cyc_activate),
        .o_cyc_must_continue (o_cyc_must_continue),
        .o_cyc_addr          (o_cyc_addr),
        .o_cyc_uds           (o_cyc_uds),
        .o_cyc_lds           (o_cyc_lds),
        .o_cyc_write         (o_cyc_write),
        .o_cyc_wdata         (o_cyc_wdata),
        .i_cyc_done          (i_cyc_done),
        .i_cyc_rdata         (i_cyc_rdata),
        .i_cyc_berr          (i_cyc_berr),
        .o_resp_valid        (o_resp_valid),
        .o_resp_rdata        (o_resp_rdata),
        .o_resp_err          (o_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          uds;
        logic          lds;
        logic          wr;
        logic [15:0]   wd;
        logic          mc;
    } cyc_t;

    typedef struct {
        logic [15:0] rd;
        logic        berr;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    cyc_t  q_cyc[$];
    bus_t  q_bus[$];
    resp_t q_resp[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_act   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_cyc(input logic [AW-1:0] a, input logic u, input logic l,
                           input logic w, input logic [15:0] wd, input logic mc,
                           input logic [15:0] rd, input logic berr);
        cyc_t c;
        bus_t b;
        c.addr = a; c.uds = u; c.lds = l; c.wr = w; c.wd = wd; c.mc = mc;
        b.rd = rd; b.berr = berr;
        q_cyc.push_back(c);
        q_bus.push_back(b);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic err);
        resp_t r;
        r.rd = rd; r.err = err;
        q_resp.push_back(r);
    endtask

    // Bus-cycle FSM model: finalizes each cycle two cycles after it starts.
    initial begin
        bit   cont;
        bus_t b;
        i_cyc_done  = 1'b0;
        i_cyc_rdata = 16'h0;
        i_cyc_berr  = 1'b0;
        forever begin
            @(negedge clk);
            if (o_cyc_activate) begin
                cont = 1'b1;
                while (cont) begin
                    repeat (2) @(negedge clk);
                    if (q_bus.size() != 0) b = q_bus.pop_front();
                    else begin b.rd = 16'h0; b.berr = 1'b0; end
                    i_cyc_done  = 1'b1;
                    i_cyc_rdata = b.rd;
                    i_cyc_berr  = b.berr;
                    #1 cont = o_cyc_must_continue;
                    @(negedge clk);
                    i_cyc_done  = 1'b0;
                    i_cyc_rdata = 16'h0;
                    i_cyc_berr  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc_t e;
        #2;
        if (o_cyc_activate) n_act++;
        if (i_cyc_done) begin
            if (q_cyc.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cyc_unexpected: got addr %h expected none", o_cyc_addr);
            end else begin
                e = q_cyc.pop_front();
                check("cycle",
                      {52'h0, o_cyc_addr, o_cyc_uds, o_cyc_lds, o_cyc_write,
                       o_cyc_wdata, o_cyc_must_continue},
                      {52'h0, e.addr, e.uds, e.lds, e.wr, e.wd, e.mc});
            end
        end
    end

    always @(negedge clk) begin
        resp_t e;
        #2;
        if (o_resp_valid) begin
            if (q_resp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got %h expected none", o_resp_rdata);
            end else begin
                e = q_resp.pop_front();
                check("resp", {63'h0, o_resp_rdata, o_resp_err}, {63'h0, e.rd, e.err});
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic w, input logic [31:0] wd, output int lat);
        int t;
        t = 0;
        while (!o_req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_size  = sz;
        i_req_write = w;
        i_req_wdata = wd;
        @(negedge clk);
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_req_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got ready=0 expected 1");
        end
    endtask

    initial begin
        int lat;
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_size  = 2'b00;
        i_req_write = 1'b0;
        i_req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_state",
              {16'h0, o_req_ready, o_cyc_activate, o_cyc_must_continue, o_cyc_addr,
               o_cyc_uds, o_cyc_lds, o_cyc_write, o_cyc_wdata, o_resp_valid,
               o_resp_rdata, o_resp_err},
              {16'h0, 1'b1, 79'h0});
        i_reset = 1'b0;
        @(negedge clk);

        exp_cyc(24'h000101, 0, 1, 0, 16'h0000, 0, 16'h12AB, 0);
        exp_resp(32'h000000AB, 0);
        do_req(24'h000101, 2'b00, 0, 32'h0, lat);
        check("byte_rd_latency", 96'(lat), 96'd5);

        exp_cyc(24'h000200, 1, 1, 1, 16'h1122, 1, 16'h0, 0);
        exp_cyc(24'h000202, 1, 1, 1, 16'h3344, 0, 16'h0, 0);
        exp_resp(32'h0, 0);
        do_req(24'h000200, 2'b10, 1, 32'h11223344, lat);

        exp_cyc(24'h000401, 0, 1, 0, 16'h0, 1, 16'h00AA, 0);
        exp_cyc(24'h000402, 1, 1, 0, 16'h0, 1, 16'hBBCC, 0);
        exp_cyc(24'h000404, 1, 0, 0, 16'h0, 0, 16'hDD00, 0);
        exp_resp(32'hAABBCCDD, 0);
        do_req(24'h000401, 2'b10, 0, 32'h0, lat);
        check("long_rd_latency", 96'(lat), 96'd11);

        exp_cyc(24'h000003, 0, 1, 0, 16'h0, 0, 16'h5566, 1);
        exp_resp(32'h0, 1);
        do_req(24'h000003, 2'b01, 0, 32'h0, lat);

        exp_cyc(24'hFFFFFF, 0, 1, 0, 16'h0, 1, 16'h0011, 0);
        exp_cyc(24'h000000, 1, 1, 0, 16'h0, 1, 16'h2233, 0);
        exp_cyc(24'h000002, 1, 0, 0, 16'h0, 0, 16'h4400, 0);
        exp_resp(32'h11223344, 0);
        do_req(24'hFFFFFF, 2'b10, 0, 32'h0, lat);

        exp_cyc(24'h000003, 0, 1, 1, 16'hBEBE, 1, 16'h0, 0);
        exp_cyc(24'h000004, 1, 0, 1, 16'hEFEF, 0, 16'h0, 0);
        exp_resp(32'h0, 0);
        do_req(24'h000003, 2'b01, 1, 32'h0000BEEF, lat);

        exp_cyc(24'h000010, 1, 0, 1, 16'h5A5A, 0, 16'h0, 0);
        exp_resp(32'h0, 0);
        do_req(24'h000010, 2'b00, 1, 32'h0000005A, lat);

        exp_cyc(24'h000301, 0, 1, 1, 16'h1111, 1, 16'h0, 0);
        exp_cyc(24'h000302, 1, 1, 1, 16'h2233, 1, 16'h0, 0);
        exp_cyc(24'h000304, 1, 0, 1, 16'h4444, 0, 16'h0, 0);
        exp_resp(32'h0, 0);
        do_req(24'h000301, 2'b10, 1, 32'h11223344, lat);

        exp_cyc(24'h000500, 1, 1, 0, 16'h0, 0, 16'hCAFE, 0);
        exp_resp(32'h0000CAFE, 0);
        do_req(24'h000500, 2'b01, 0, 32'h0, lat);

        exp_resp(32'h0, 1);
        do_req(24'h000600, 2'b11, 0, 32'h0, lat);
        check("reserved_latency", 96'(lat), 96'd2);

        // Reset while BUSY: the late DONE must see idle, zeroed outputs.
        exp_cyc(24'h0, 0, 0, 0, 16'h0, 0, 16'h7777, 0);
        i_req_valid = 1'b1;
        i_req_addr  = 24'h000700;
        i_req_size  = 2'b10;
        i_req_write = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("reset_busy",
              {16'h0, o_req_ready, o_cyc_activate, o_cyc_must_continue, o_cyc_addr,
               o_cyc_uds, o_cyc_lds, o_cyc_write, o_cyc_wdata, o_resp_valid,
               o_resp_rdata, o_resp_err},
              {16'h0, 1'b1, 79'h0});
        repeat (3) @(negedge clk);
        check("after_late_done", {94'h0, o_req_ready, o_resp_valid}, {94'h0, 1'b1, 1'b0});

        repeat (10) @(negedge clk);
        check("queues_empty", 96'(q_cyc.size() + q_bus.size() + q_resp.size()), 96'd0);
        check("activate_count", 96'(n_act), 96'd10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
